cell_drawer: RTL and testbench

CELL_DRAWER -- requirements
Module: cell_drawer

---
 rtl/cell_drawer_pkg.sv | 46 ++++
 rtl/cell_drawer_if.sv | 26 ++
 rtl/cell_raster_counter.sv | 44 ++++
 rtl/cell_drawer.sv | 132 +++++++++++++
 tb/tb_cell_drawer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cell_drawer_pkg.sv
// Shared board geometry, colour codes and cell-write command layout for the cell drawer.
package cell_drawer_pkg;

  localparam int unsigned CELL_SIZE  = 16;
  localparam int unsigned BOARD_COLS = 7;
  localparam int unsigned BOARD_ROWS = 6;

  localparam int unsigned X_W        = 8;
  localparam int unsigned Y_W        = 7;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned FIELD_W    = 4;
  localparam int unsigned CMD_W      = 11;
  localparam int unsigned COL_LSB    = 0;
  localparam int unsigned ROW_LSB    = 4;
  localparam int unsigned COLOUR_LSB = 8;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_BLUE  = 3'b001;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef struct packed {
    colour_t             colour;
    logic [FIELD_W-1:0]  row;
    logic [FIELD_W-1:0]  col;
  } cell_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } state_t;

  function automatic cell_cmd_t decode_cmd(input logic [CMD_W-1:0] raw);
    cell_cmd_t c;
    c.colour = raw[COLOUR_LSB +: COLOUR_W];
    c.row    = raw[ROW_LSB +: FIELD_W];
    c.col    = raw[COL_LSB +: FIELD_W];
    return c;
  endfunction

  function automatic logic cmd_in_range(input cell_cmd_t c);
    return (32'(c.col) < BOARD_COLS) && (32'(c.row) < BOARD_ROWS);
  endfunction

endpackage

// File: rtl/cell_drawer_if.sv
// Command handshake and VGA pixel-write bus between a controller and the cell drawer.
interface cell_drawer_if;
  import cell_drawer_pkg::*;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_ready;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  colour_t           colour;
  logic              plot;
  logic              draw_done;
  logic              busy;
  logic              err;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, x, y, colour, plot, draw_done, busy, err
  );

  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, x, y, colour, plot, draw_done, busy, err
  );

endinterface

// File: rtl/cell_raster_counter.sv
// Raster offset generator: presents the offsets of the next pixel to emit and flags the final pixel.
module cell_raster_counter #(
  parameter int unsigned CELL_SIZE = 16,
  parameter int unsigned OFF_W     = $clog2(CELL_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [OFF_W-1:0] xo_c,
  output logic [OFF_W-1:0] yo_c,
  output logic             last_c
);

  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(CELL_SIZE - 1);

  logic [OFF_W-1:0] xo;
  logic [OFF_W-1:0] yo;

  // x offset runs fastest; both wrap to zero without carrying further
  always_comb begin
    xo_c   = xo;
    yo_c   = yo;
    last_c = (xo == OFF_MAX) && (yo == OFF_MAX);
    if (advance) begin
      if (xo == OFF_MAX) begin
        xo_c = '0;
        yo_c = (yo == OFF_MAX) ? '0 : yo + OFF_W'(1);
      end else begin
        xo_c = xo + OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xo <= '0;
      yo <= '0;
    end else begin
      xo <= xo_c;
      yo <= yo_c;
    end
  end

endmodule

// File: rtl/cell_drawer.sv
// Draws one framed board cell per accepted command as a raster of registered VGA pixel writes.
module cell_drawer #(
  parameter int unsigned CELL_SIZE     = cell_drawer_pkg::CELL_SIZE,
  parameter int unsigned X0            = 24,
  parameter int unsigned Y0            = 12,
  parameter logic [2:0]  BORDER_COLOUR = cell_drawer_pkg::COLOUR_BLUE
) (
  input  logic          clk,
  input  logic          reset,
  cell_drawer_if.slave  bus
);
  import cell_drawer_pkg::*;

  localparam int unsigned OFF_W = $clog2(CELL_SIZE);

  state_t           state, state_n;
  cell_cmd_t        pending, pending_n;
  cell_cmd_t        active, active_n;
  cell_cmd_t        cmd_in, src_c;
  logic             pending_valid, pending_valid_n;
  logic             accept_c, start_c, advance_c, last_c, interior_c;
  logic [OFF_W-1:0] xo_c, yo_c;
  logic [X_W-1:0]   x_n;
  logic [Y_W-1:0]   y_n;
  colour_t          colour_n;
  logic             plot_n, done_n, err_n, busy_n;

  assign cmd_in   = decode_cmd(bus.cmd);
  assign accept_c = bus.cmd_valid & ~pending_valid;

  cell_raster_counter #(
    .CELL_SIZE (CELL_SIZE),
    .OFF_W     (OFF_W)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .advance (advance_c),
    .xo_c    (xo_c),
    .yo_c    (yo_c),
    .last_c  (last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pending_valid <= 1'b0;
      pending       <= '0;
      active        <= '0;
    end else begin
      state         <= state_n;
      pending_valid <= pending_valid_n;
      pending       <= pending_n;
      active        <= active_n;
    end
  end

  // Outputs are computed one cycle ahead so the registered pixel lines up with plot
  always_comb begin
    state_n         = state;
    pending_valid_n = pending_valid;
    pending_n       = pending;
    active_n        = active;
    start_c         = 1'b0;
    advance_c       = 1'b0;
    plot_n          = 1'b0;
    done_n          = 1'b0;
    err_n           = accept_c & ~cmd_in_range(cmd_in);

    case (state)
      ST_IDLE, ST_DONE: begin
        if (pending_valid) begin
          state_n         = ST_DRAW;
          active_n        = pending;
          pending_valid_n = 1'b0;
          start_c         = 1'b1;
          plot_n          = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DRAW: begin
        advance_c = 1'b1;
        if (last_c) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          plot_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Out-of-range commands are consumed without ever reaching the pending slot
    if (accept_c && cmd_in_range(cmd_in)) begin
      pending_valid_n = 1'b1;
      pending_n       = cmd_in;
    end

    src_c      = start_c ? pending : active;
    x_n        = X_W'(X0 + 32'(src_c.col) * CELL_SIZE + 32'(xo_c));
    y_n        = Y_W'(Y0 + 32'(src_c.row) * CELL_SIZE + 32'(yo_c));
    interior_c = (32'(xo_c) >= 32'd2) && (32'(xo_c) <= CELL_SIZE - 32'd3) &&
                 (32'(yo_c) >= 32'd2) && (32'(yo_c) <= CELL_SIZE - 32'd3);
    colour_n   = interior_c ? src_c.colour : BORDER_COLOUR;
    busy_n     = (state_n != ST_IDLE) | pending_valid_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.x         <= '0;
      bus.y         <= '0;
      bus.colour    <= COLOUR_BLACK;
      bus.plot      <= 1'b0;
      bus.draw_done <= 1'b0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      bus.plot      <= plot_n;
      bus.draw_done <= done_n;
      bus.err       <= err_n;
      bus.busy      <= busy_n;
      bus.cmd_ready <= ~pending_valid_n;
      if (plot_n) begin
        bus.x      <= x_n;
        bus.y      <= y_n;
        bus.colour <= colour_n;
      end
    end
  end

endmodule

// File: tb/tb_cell_drawer.sv
// Self-checking bench for cell_drawer: directed timing scenarios plus random cells against a pixel-list model.
module tb_cell_drawer;

  localparam int CS = 16;
  localparam int BX = 24;
  localparam int BY = 12;
  localparam int BC = 1;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  pix_t exp_q[$];

  cell_drawer_if bus();

  cell_drawer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [10:0] mk_cmd(input int colour, input int row, input int col);
    return {3'(colour), 4'(row), 4'(col)};
  endfunction

  // Model: an accepted cell is the full raster of its pixels, in drawing order
  task automatic push_cell(input int colour, input int row, input int col);
    pix_t p;
    for (int yo = 0; yo < CS; yo++) begin
      for (int xo = 0; xo < CS; xo++) begin
        p.x = BX + col * CS + xo;
        p.y = BY + row * CS + yo;
        p.c = (xo >= 2 && xo <= CS - 3 && yo >= 2 && yo <= CS - 3) ? colour : BC;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic offer(input int colour, input int row, input int col, input bit expect_ready);
    chk("cmd_ready_offer", 32'(bus.cmd_ready), 32'(expect_ready));
    bus.cmd_valid = 1'b1;
    bus.cmd       = mk_cmd(colour, row, col);
    if (expect_ready && row < 6 && col < 7) push_cell(colour, row, col);
  endtask

  task automatic wait_done(input int bound, output int plots, output int cycles);
    bit seen = 1'b0;
    plots  = 0;
    cycles = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      cycles++;
      if (bus.plot === 1'b1) plots++;
      if (bus.draw_done === 1'b1) seen = 1'b1;
    end
    chk("draw_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic draw_cell(input int colour, input int row, input int col);
    int p, cy;
    offer(colour, row, col, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("pend_plot", 32'(bus.plot), 32'd0);
    chk("pend_busy", 32'(bus.busy), 32'd1);
    chk("pend_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("first_plot", 32'(bus.plot), 32'd1);
    wait_done(300, p, cy);
    chk("plot_count", 32'(p), 32'd255);
    chk("done_cycle", 32'(cy), 32'd256);
    chk("done_plot", 32'(bus.plot), 32'd0);
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.draw_done), 32'd0);
  endtask

  task automatic reject(input int colour, input int row, input int col);
    offer(colour, row, col, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rej_err", 32'(bus.err), 32'd1);
    chk("rej_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rej_plot", 32'(bus.plot), 32'd0);
    chk("rej_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("rej_err_pulse", 32'(bus.err), 32'd0);
    chk("rej_plot2", 32'(bus.plot), 32'd0);
    chk("rej_done", 32'(bus.draw_done), 32'd0);
  endtask

  // Every plotted pixel must be the next one the model expects
  always @(negedge clk) begin
    pix_t p;
    if (reset === 1'b0 && bus.plot === 1'b1) begin
      chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("pix_x", 32'(bus.x), 32'(p.x));
        chk("pix_y", 32'(bus.y), 32'(p.y));
        chk("pix_colour", 32'(bus.colour), 32'(p.c));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, cy, early;
    int colour, row, col;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;

    // Reset values
    repeat (2) tick();
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_colour", 32'(bus.colour), 32'd0);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_done", 32'(bus.draw_done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Colour 2, row 2, column 3: latency, first border pixel and first interior pixel
    offer(2, 2, 3, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("c1_n1_plot", 32'(bus.plot), 32'd0);
    tick();
    chk("c1_n2_plot", 32'(bus.plot), 32'd1);
    chk("c1_first_x", 32'(bus.x), 32'd72);
    chk("c1_first_y", 32'(bus.y), 32'd44);
    chk("c1_first_colour", 32'(bus.colour), 32'd1);
    repeat (34) tick();
    chk("c1_in_x", 32'(bus.x), 32'd74);
    chk("c1_in_y", 32'(bus.y), 32'd46);
    chk("c1_in_colour", 32'(bus.colour), 32'd2);
    wait_done(300, p, cy);
    chk("c1_plots", 32'(p), 32'd221);
    chk("c1_done_cycle", 32'(cy), 32'd222);
    tick();
    chk("c1_idle_busy", 32'(bus.busy), 32'd0);

    // Out-of-range column and row
    reject(4, 0, 7);
    reject(4, 6, 0);

    // Back-to-back: second accepted during DRAW, third held off until the first completes
    offer(3, 0, 0, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("bb_a_plot", 32'(bus.plot), 32'd1);
    offer(4, 0, 1, 1'b1);
    tick();
    offer(5, 0, 2, 1'b0);
    early = 0;
    for (int i = 0; i < 300 && bus.draw_done !== 1'b1; i++) begin
      tick();
      if (bus.cmd_ready !== 1'b0) early++;
    end
    chk("bb_held_off", 32'(early), 32'd0);
    chk("bb_a_done", 32'(bus.draw_done), 32'd1);
    chk("bb_gap_plot", 32'(bus.plot), 32'd0);
    tick();
    chk("bb_b_plot", 32'(bus.plot), 32'd1);
    offer(5, 0, 2, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    wait_done(300, p, cy);
    chk("bb_b_plots", 32'(p), 32'd254);
    tick();
    chk("bb_c_plot", 32'(bus.plot), 32'd1);
    wait_done(300, p, cy);
    chk("bb_c_plots", 32'(p), 32'd255);
    tick();
    chk("bb_idle_busy", 32'(bus.busy), 32'd0);

    // Command presented in the DONE cycle
    offer(1, 3, 4, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    wait_done(300, p, cy);
    chk("dn_plots", 32'(p), 32'd256);
    offer(2, 4, 5, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("dn_n1_plot", 32'(bus.plot), 32'd0);
    tick();
    chk("dn_n2_plot", 32'(bus.plot), 32'd1);
    wait_done(300, p, cy);
    chk("dn_plots2", 32'(p), 32'd255);
    tick();

    // Reset at pixel 100 aborts the cell
    offer(5, 1, 1, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (101) tick();
    chk("ar_plot_before", 32'(bus.plot), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_plot", 32'(bus.plot), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_done", 32'(bus.draw_done), 32'd0);
    chk("ar_ready", 32'(bus.cmd_ready), 32'd1);
    exp_q.delete();
    early = 0;
    repeat (3) begin
      tick();
      if (bus.draw_done !== 1'b0) early++;
    end
    chk("ar_no_done", 32'(early), 32'd0);
    reset = 1'b0;
    tick();
    draw_cell(6, 5, 6);

    // Random commands, mixing valid and out-of-range fields
    for (int i = 0; i < 8; i++) begin
      colour = int'($urandom_range(0, 7));
      row    = int'($urandom_range(0, 7));
      col    = int'($urandom_range(0, 8));
      if (row < 6 && col < 7) draw_cell(colour, row, col);
      else reject(colour, row, col);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
